// File: rtl/divisor_pkg.sv
// ---------------------------------------------------------------------------
// divisor_pkg : FSM state encodings shared by the sequential divider
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package divisor_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t FIM  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/divisor_passo.sv
// ---------------------------------------------------------------------------
// divisor_passo : one restoring-division step (shift in a bit, trial
//                 subtract, restore on borrow)
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module divisor_passo #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // The extra top bit of diff is the borrow of the trial subtraction.
  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {2'b00, divisor};
  assign q_bit   = ~diff[WIDTH+1];
  assign rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

`default_nettype wire

// File: rtl/divisor_nbits_seq.sv
// ---------------------------------------------------------------------------
// divisor_nbits_seq : WIDTH-cycle restoring divider with divide-by-zero flag.
//                     Define DIVISOR_SIGNED_EN for two's-complement operands.
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module divisor_nbits_seq
  import divisor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             ERR
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic             pend;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   rem_nxt;
  logic             q_bit;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

  assign accept = start & (((state == IDLE) & ~pend) | (state == FIM));
  assign last   = (state == CALC) && (cnt == CNT_W'(WIDTH - 1));
  assign q_fin  = {dvd[WIDTH-2:0], q_bit};
  assign r_fin  = rem_nxt[WIDTH-1:0];

`ifdef DIVISOR_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign a_mag = A[WIDTH-1] ? -A : A;
  assign b_mag = B[WIDTH-1] ? -B : B;
  assign q_out = neg_q ? -q_fin : q_fin;
  assign r_out = neg_r ? -r_fin : r_fin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
      neg_r <= A[WIDTH-1];
    end
  end
`else
  assign a_mag = A;
  assign b_mag = B;
  assign q_out = q_fin;
  assign r_out = r_fin;
`endif

  divisor_passo #(.WIDTH(WIDTH)) u_passo (
    .rem_in  (rem),
    .bit_in  (dvd[WIDTH-1]),
    .divisor (dvs),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An accepted start parks one cycle in IDLE (pend) before CALC or FIM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend) state_nxt = (dvs == '0) ? FIM : CALC;
      CALC:    if (last) state_nxt = FIM;
      FIM:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == FIM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= 1'b0;
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      a_raw <= '0;
      rem   <= '0;
      Q     <= '0;
      R     <= '0;
      ERR   <= 1'b0;
    end else begin
      pend <= accept;
      if (accept) begin
        dvd   <= a_mag;
        dvs   <= b_mag;
        a_raw <= A;
      end
      if (pend) begin
        rem <= '0;
        cnt <= '0;
        if (dvs == '0) begin
          ERR <= 1'b1;
          Q   <= '1;
          R   <= a_raw;
        end else begin
          ERR <= 1'b0;
        end
      end
      if (state == CALC) begin
        rem <= rem_nxt;
        dvd <= q_fin;
        cnt <= cnt + 1'b1;
        if (last) begin
          Q <= q_out;
          R <= r_out;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_divisor_nbits_seq.sv
// ---------------------------------------------------------------------------
// tb_divisor_nbits_seq : directed and random checks of divisor_nbits_seq
//                        against a timeline/arithmetic reference model
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_divisor_nbits_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         ERR;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  divisor_nbits_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R),
    .ERR   (ERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void calc(input logic [W-1:0] a, input logic [W-1:0] b,
                               output logic [W-1:0] q, output logic [W-1:0] r);
`ifdef DIVISOR_SIGNED_EN
    int ia;
    int ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    q  = W'(ia / ib);
    r  = W'(ia % ib);
`else
    q = a / b;
    r = a % b;
`endif
  endfunction

  // Reference model: an accepted start at edge e yields results at edge d.
  bit           flight = 1'b0;
  int           e_edge = 0;
  int           d_edge = 0;
  bit           mbz    = 1'b0;
  logic [W-1:0] ma, mq, mr;
  logic [W-1:0] eq = '0, er = '0;
  bit           eerr = 1'b0, ebusy = 1'b0, edone = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      flight = 1'b0;
      eq     = '0;
      er     = '0;
      eerr   = 1'b0;
    end else begin
      if (flight && cyc == e_edge + 1) begin
        eerr = mbz;
        if (mbz) begin
          eq = '1;
          er = ma;
        end
      end
      if (flight && cyc == d_edge && !mbz) begin
        eq = mq;
        er = mr;
      end
      if (start && (!flight || cyc > d_edge)) begin
        flight = 1'b1;
        e_edge = cyc;
        ma     = A;
        mbz    = (B == '0);
        d_edge = mbz ? cyc + 1 : cyc + W + 1;
        if (!mbz) calc(A, B, mq, mr);
      end else if (flight && cyc > d_edge) begin
        flight = 1'b0;
      end
    end
    ebusy = flight && !mbz && cyc >= e_edge + 1 && cyc < d_edge;
    edone = flight && cyc == d_edge;
    #1;
    chk("busy", 32'(busy), 32'(ebusy));
    chk("done", 32'(done), 32'(edone));
    chk("Q",    32'(Q),    32'(eq));
    chk("R",    32'(R),    32'(er));
    chk("ERR",  32'(ERR),  32'(eerr));
  end

  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
    @(negedge clk);
    start = 1'b1;
    A     = a;
    B     = b;
    acc   = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int at, output int nbusy);
    at    = -1;
    nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        at = cyc;
        break;
      end
      if (busy) nbusy++;
      @(negedge clk);
    end
    if (at < 0) chk({name, " done timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int ae, ae2, at, at2, nb;
    bit spurious;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge clk);
    chk("reset Q",    32'(Q),    32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;

    go(4'd13, 4'd3, ae);
    wait_done("13/3", at, nb);
    chk("13/3 latency", 32'(at - ae), 32'd5);
    chk("13/3 busy cycles", 32'(nb), 32'd4);
    chk("13/3 Q", 32'(Q), 32'd4);
    chk("13/3 R", 32'(R), 32'd1);
    chk("13/3 ERR", 32'(ERR), 32'd0);
    chk("model 13/3 Q", 32'(eq), 32'd4);

    go(4'd7, 4'd0, ae);
    wait_done("7/0", at, nb);
    chk("7/0 latency", 32'(at - ae), 32'd1);
    chk("7/0 busy cycles", 32'(nb), 32'd0);
    chk("7/0 ERR", 32'(ERR), 32'd1);
    chk("7/0 Q", 32'(Q), 32'd15);
    chk("7/0 R", 32'(R), 32'd7);

    repeat (2) @(negedge clk);
    go(4'd15, 4'd1, ae);
    wait_done("15/1", at, nb);
    chk("15/1 Q", 32'(Q), 32'd15);
    chk("15/1 R", 32'(R), 32'd0);
    start = 1'b1;
    A     = 4'd5;
    B     = 4'd7;
    ae2   = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    wait_done("5/7", at2, nb);
    chk("5/7 latency", 32'(at2 - ae2), 32'd5);
    chk("b2b spacing", 32'(at2 - at), 32'd6);
    chk("5/7 Q", 32'(Q), 32'd0);
    chk("5/7 R", 32'(R), 32'd5);

    repeat (2) @(negedge clk);
    go(4'd9, 4'd2, ae);
    @(negedge clk);
    start = 1'b1;
    A     = 4'd1;
    B     = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done("9/2", at, nb);
    chk("9/2 latency", 32'(at - ae), 32'd5);
    chk("9/2 Q", 32'(Q), 32'd4);
    chk("9/2 R", 32'(R), 32'd1);

    repeat (2) @(negedge clk);
    go(4'd14, 4'd3, ae);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort Q",    32'(Q),    32'd0);
    chk("abort R",    32'(R),    32'd0);
    chk("abort ERR",  32'(ERR),  32'd0);
    rst = 1'b0;
    spurious = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) spurious = 1'b1;
    end
    chk("abort no done", 32'(spurious), 32'd0);
    go(4'd14, 4'd3, ae);
    wait_done("14/3", at, nb);
    chk("14/3 Q", 32'(Q), 32'd4);
    chk("14/3 R", 32'(R), 32'd2);

`ifdef DIVISOR_SIGNED_EN
    repeat (2) @(negedge clk);
    go(4'b1001, 4'd2, ae);
    wait_done("-7/2", at, nb);
    chk("-7/2 Q", 32'(Q), 32'b1101);
    chk("-7/2 R", 32'(R), 32'b1111);
    repeat (2) @(negedge clk);
    go(4'b1000, 4'b1111, ae);
    wait_done("-8/-1", at, nb);
    chk("-8/-1 Q",   32'(Q),   32'b1000);
    chk("-8/-1 R",   32'(R),   32'd0);
    chk("-8/-1 ERR", 32'(ERR), 32'd0);
`endif

    repeat (3000) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      A     = W'($urandom);
      B     = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      rst   = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/divisor_nbits_seq.md
DIVISOR_NBITS_SEQ -- requirements
Module: divisor_nbits_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a division with the current A and B.
REQ-005 SHALL have port A, input, WIDTH bits: dividend.
REQ-006 SHALL have port B, input, WIDTH bits: divisor.
REQ-007 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when Q, R and ERR become valid.
REQ-009 SHALL have port Q, output, WIDTH bits: quotient.
REQ-010 SHALL have port R, output, WIDTH bits: remainder.
REQ-011 SHALL have port ERR, output, 1 bit: divide-by-zero flag.

Function
REQ-012 SHALL implement a 3-state FSM with states IDLE, CALC and FIM.
REQ-013 SHALL accept start only in IDLE or FIM, capturing A and B on that edge; start in CALC is ignored and the captured operands are not disturbed.
REQ-014 SHALL, on accepted start with B!=0, enter CALC and perform restoring division with one quotient bit per cycle, MSB first, over exactly WIDTH cycles.
REQ-015 SHALL use a WIDTH+1-bit partial remainder per step: trial subtract; if borrow, restore and set the quotient bit to 0, else keep the difference and set the bit to 1.
REQ-016 SHALL assert done in the cycle WIDTH+1 edges after the accepting edge, with latency independent of operand values.
REQ-017 SHALL, on accepted start with B==0, go to FIM on the next edge with ERR=1, Q=all ones and R=A; done is asserted on that edge (latency 1).
REQ-018 SHALL keep busy=1 exactly while in CALC.
REQ-019 SHALL make done high only in FIM; FIM returns to IDLE next cycle unless a new start is accepted.
REQ-020 SHALL hold Q, R and ERR stable from done until the edge after the next accepted start, when ERR is cleared.
REQ-021 SHALL accept a start asserted during the done cycle, giving back-to-back operation with no idle gap.

Reset
REQ-022 SHALL, on rst=1 at any time including mid-CALC, abort the division and force the FSM to IDLE with busy=0, done=0, Q=0, R=0 and ERR=0.
REQ-023 SHALL ignore start while rst=1, and the first start after rst falls SHALL be accepted normally.

Configuration
REQ-024 SHALL support macro DIVISOR_SIGNED_EN: when defined, A, B, Q and R are two's complement; the divider divides magnitudes, the quotient truncates toward zero, the remainder takes the dividend's sign, and latency stays unchanged.
REQ-025 SHALL, when DIVISOR_SIGNED_EN is undefined, treat all operands as unsigned and synthesise no sign logic.
REQ-026 SHALL, in signed mode, produce the WIDTH-bit wrapped result for most-negative / -1 (Q=most-negative, R=0) with ERR=0.

Structure
REQ-027 SHALL take the FSM state encodings (IDLE, CALC, FIM) and the state width constant from shared package divisor_pkg.
REQ-028 SHALL instantiate one sub-module, divisor_passo, as the combinational single-step trial-subtract/restore cell; the iteration counter, shift registers and FSM stay in the top module.

Verification (WIDTH=4)
REQ-029 SHALL verify A=13, B=3, start at edge 0 -> busy for 4 cycles, done at edge 5, Q=4, R=1, ERR=0.
REQ-030 SHALL verify A=7, B=0 -> done at edge 1, ERR=1, Q=15, R=7, busy never high.
REQ-031 SHALL verify A=15, B=1 followed by a start during the done cycle with A=5, B=7 -> Q=15, R=0, then Q=0, R=5 with no idle cycle between.
REQ-032 SHALL verify A=9, B=2 started, then start with A=1, B=1 at edge 2 -> second start ignored, result Q=4, R=1.
REQ-033 SHALL verify rst pulsed at edge 3 of A=14, B=3 -> all outputs 0, FSM in IDLE, no done, then a fresh run gives Q=4, R=2.
REQ-034 SHALL verify, with DIVISOR_SIGNED_EN defined, A=4'b1001 (-7), B=2 -> Q=4'b1101 (-3), R=4'b1111 (-1).
